// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer for a two-digit BCD capture register.
// Optional inactivity timeout: define KEYPAD_TIMEOUT_EN.
module keypad_entry_ctrl #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] tecla_d,
    output logic       load_u,
    output logic       load_d,
    output logic       rdy,
    output logic [1:0] digit_cnt,
    output logic       busy,
    output logic       key_drop,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE, HOLD, LD_D, LD_U, CLR_D, CLR_U, READY
    } state_t;

    state_t     state, state_n;
    logic [3:0] unit_q, unit_n;
    logic [3:0] new_q, new_n;
    logic [3:0] tecla_n;
    logic [1:0] cnt_n;
    logic       drop_n, tmo_n;
    logic       is_digit, is_enter, is_clear;
    logic       waiting, expired;

    assign is_digit = (key_code <= 4'd9);
    assign is_enter = (key_code == 4'hA);
    assign is_clear = (key_code == 4'hB);
    assign waiting  = (state == IDLE) || (state == HOLD);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] tmo_cnt;

    assign expired = (state == HOLD) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (state != HOLD || key_valid || expired)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    // Never true: without the counter HOLD waits indefinitely.
    assign expired = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_n = state;
        new_n   = new_q;
        unit_n  = unit_q;
        cnt_n   = digit_cnt;
        tecla_n = tecla_d;
        drop_n  = 1'b0;
        tmo_n   = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (key_valid) begin
                    unique case (1'b1)
                        is_digit: begin
                            new_n   = key_code;
                            state_n = LD_D;
                        end
                        is_clear: state_n = CLR_D;
                        is_enter: begin
                            if (state == HOLD) state_n = READY;
                            else               drop_n  = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (expired) begin
                    tmo_n   = 1'b1;
                    state_n = CLR_D;
                end
            end
            LD_D:  state_n = LD_U;
            LD_U:  state_n = HOLD;
            CLR_D: state_n = CLR_U;
            CLR_U: begin
                state_n = IDLE;
                cnt_n   = 2'd0;
                unit_n  = 4'd0;
            end
            READY: begin
                state_n = IDLE;
                cnt_n   = 2'd0;
            end
            default: state_n = IDLE;
        endcase
        if (!waiting && key_valid)
            drop_n = 1'b1;
        // Register-facing data is decoded from the state being entered.
        case (state_n)
            LD_D: tecla_n = (digit_cnt == 2'd0) ? 4'd0 : unit_q;
            LD_U: begin
                tecla_n = new_q;
                unit_n  = new_q;
                cnt_n   = (digit_cnt == 2'd2) ? 2'd2 : digit_cnt + 2'd1;
            end
            CLR_D, CLR_U: tecla_n = 4'd0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            new_q     <= 4'd0;
            unit_q    <= 4'd0;
            digit_cnt <= 2'd0;
            tecla_d   <= 4'd0;
            load_d    <= 1'b0;
            load_u    <= 1'b0;
            rdy       <= 1'b0;
            busy      <= 1'b0;
            key_drop  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            new_q     <= new_n;
            unit_q    <= unit_n;
            digit_cnt <= cnt_n;
            tecla_d   <= tecla_n;
            load_d    <= (state_n == LD_D) || (state_n == CLR_D);
            load_u    <= (state_n == LD_U) || (state_n == CLR_U);
            rdy       <= (state_n == READY);
            busy      <= !((state_n == IDLE) || (state_n == HOLD));
            key_drop  <= drop_n;
            timeout   <= tmo_n;
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl with a model capture register.
// Timeout scenario runs when KEYPAD_TIMEOUT_EN is defined.
module tb_keypad_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] tecla_d;
    logic       load_u, load_d, rdy;
    logic [1:0] digit_cnt;
    logic       busy, key_drop, timeout;

    int n_chk  = 0;
    int n_pass = 0;

    logic [9:0] q[$];
    logic [3:0] m_tens, m_units;
    logic [1:0] m_cnt;
    logic [3:0] cap_t, cap_u;
    logic [7:0] cap_o;

    keypad_entry_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .tecla_d   (tecla_d),
        .load_u    (load_u),
        .load_d    (load_d),
        .rdy       (rdy),
        .digit_cnt (digit_cnt),
        .busy      (busy),
        .key_drop  (key_drop),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [9:0] ev(input logic [1:0] k,
                                      input logic [7:0] v);
        return {k, v};
    endfunction

    // Predict the register-facing pulses for one accepted key.
    task automatic model_key(input logic [3:0] c);
        if (c <= 4'd9) begin
            q.push_back(ev(2'd1, {4'd0, (m_cnt == 2'd0) ? 4'd0 : m_units}));
            q.push_back(ev(2'd2, {4'd0, c}));
            m_tens  = (m_cnt == 2'd0) ? 4'd0 : m_units;
            m_units = c;
            m_cnt   = (m_cnt == 2'd2) ? 2'd2 : m_cnt + 2'd1;
        end else if (c == 4'hB) begin
            q.push_back(ev(2'd1, 8'h00));
            q.push_back(ev(2'd2, 8'h00));
            m_tens  = 4'd0;
            m_units = 4'd0;
            m_cnt   = 2'd0;
        end else if (c == 4'hA) begin
            if (m_cnt != 2'd0)
                q.push_back(ev(2'd3, {m_tens, m_units}));
            m_cnt = 2'd0;
        end
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] c);
        model_key(c);
        press(c);
    endtask

    // Monitor: compare each pulse with the scoreboard, model the register.
    always @(negedge clk) begin
        logic [9:0] obs;
        if (!rst) begin
            cap_t = 4'd0;
            cap_u = 4'd0;
            cap_o = 8'd0;
        end else if (load_d || load_u || rdy) begin
            check("onehot", 32'($countones({load_d, load_u, rdy})), 32'd1);
            if (load_d)      obs = ev(2'd1, {4'd0, tecla_d});
            else if (load_u) obs = ev(2'd2, {4'd0, tecla_d});
            else             obs = ev(2'd3, {cap_t, cap_u});
            if (q.size() == 0)
                check("sb_underflow", {22'd0, obs}, 32'd0);
            else
                check("sb_pulse", {22'd0, obs}, {22'd0, q.pop_front()});
            if (load_u)      cap_u = tecla_d;
            else if (load_d) cap_t = tecla_d;
            else             cap_o = {cap_t, cap_u};
        end
    end

    initial begin
        int first, hits;
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        m_tens    = 4'd0;
        m_units   = 4'd0;
        m_cnt     = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_outs", {tecla_d, load_u, load_d, rdy, busy, key_drop,
                           timeout, digit_cnt}, 32'd0);
        rst = 1'b1;

        // Asynchronous reset in the middle of LD_D.
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd3;
        @(posedge clk);
        #1 key_valid = 1'b0;
        check("mid_ld_d", {load_d, busy}, 32'h3);
        #1 rst = 1'b0;
        #1 check("async_rst", {tecla_d, load_u, load_d, rdy, busy, key_drop,
                               timeout, digit_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst", {busy, load_d, load_u, digit_cnt}, 32'd0);

        key(4'd4);
        key(4'd7);
        check("cnt_47", digit_cnt, m_cnt);
        key(4'hA);
        check("out_47", cap_o, 8'h47);
        check("cnt_0", digit_cnt, 2'd0);

        key(4'd1);
        key(4'd2);
        key(4'd3);
        check("cnt_sat", digit_cnt, 2'd2);
        key(4'hA);
        check("out_23", cap_o, 8'h23);

        // Second strobe on the cycle after an accepted digit.
        model_key(4'd5);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd5;
        @(negedge clk);
        key_code  = 4'd6;
        check("busy_n1", busy, 1'b1);
        @(negedge clk);
        key_valid = 1'b0;
        check("drop_n2", key_drop, 1'b1);
        @(negedge clk);
        check("drop_width", key_drop, 1'b0);
        repeat (2) @(negedge clk);
        key(4'hA);
        check("out_05", cap_o, 8'h05);

        key(4'd9);
        key(4'hB);
        check("clr_cnt", {digit_cnt, busy}, 32'd0);
        check("clr_reg", {cap_t, cap_u}, 8'h00);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hA;
        @(negedge clk);
        key_valid = 1'b0;
        check("drop_enter", key_drop, 1'b1);
        repeat (3) @(negedge clk);

        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hD;
        @(negedge clk);
        key_valid = 1'b0;
        check("ignored", {key_drop, busy}, 32'd0);
        repeat (3) @(negedge clk);

        model_key(4'd6);
`ifdef KEYPAD_TIMEOUT_EN
        model_key(4'hB);
`endif
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd6;
        first = 0;
        hits  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            key_valid = 1'b0;
            if (timeout) begin
                hits++;
                if (first == 0) first = i;
            end
        end
`ifdef KEYPAD_TIMEOUT_EN
        check("tmo_at", first, 19);
        check("tmo_width", hits, 1);
        check("tmo_cnt", {digit_cnt, busy}, 32'd0);
`else
        check("no_tmo", hits, 0);
        check("hold_cnt", digit_cnt, 2'd1);
        key(4'hB);
        check("clr_cnt2", digit_cnt, 2'd0);
`endif

        check("sb_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
